// File: rtl/nmr_echo_acquirer_if.sv
// AXI-Stream beat channel from the echo acquirer towards the DMA engine.
interface nmr_echo_acquirer_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/nmr_echo_acquirer.sv
// Gates ADC samples into echo windows after each receiver-blank fall and streams them out.
// Optional NMR_ACQ_TIMESTAMP_EN prefixes every window with a us-since-sync header beat.
module nmr_echo_acquirer #(
  parameter int DATA_W     = 14,
  parameter int US_DIVIDER = 125,
  parameter int FIFO_AW    = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  sync_in,
  input  logic                  blank_in,
  input  logic [DATA_W-1:0]     adc_data,
  input  logic                  adc_valid,
  input  logic [31:0]           acq_dly_in,
  input  logic [15:0]           acq_len_in,
  input  logic [15:0]           win_cnt_in,
  nmr_echo_acquirer_if.master   m_axis,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int DIV_W = (US_DIVIDER > 1) ? $clog2(US_DIVIDER) : 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(US_DIVIDER - 1);
  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_WAIT_BLANK, S_DELAY, S_CAPTURE, S_DONE
  } state_e;

  state_e state_q;

  logic arm_q, arm_prev_q, sync_q, sync_prev_q, blank_q, blank_prev_q;
  logic [DIV_W-1:0] div_q;
  logic [31:0] dly_cfg_q, dly_q;
  logic [15:0] len_cfg_q, win_cfg_q, smp_q, win_done_q;
  logic busy_q, done_q, overflow_q;

  logic arm_rise, sync_rise, blank_fall, tick;
  logic arm_accept, enter_cap, cap_beat, win_end, last_win;
  logic        wr_en, wr_last;
  logic [31:0] wr_data, sample_ext;

  // ---------------------------------------------------------------- inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q        <= 1'b0;
      arm_prev_q   <= 1'b0;
      sync_q       <= 1'b0;
      sync_prev_q  <= 1'b0;
      blank_q      <= 1'b0;
      blank_prev_q <= 1'b0;
    end else begin
      arm_q        <= arm;
      arm_prev_q   <= arm_q;
      sync_q       <= sync_in;
      sync_prev_q  <= sync_q;
      blank_q      <= blank_in;
      blank_prev_q <= blank_q;
    end
  end

  assign arm_rise   = arm_q & ~arm_prev_q;
  assign sync_rise  = sync_q & ~sync_prev_q;
  assign blank_fall = ~blank_q & blank_prev_q;

  // Free-running microsecond tick
  always_ff @(posedge clk) begin
    if (rst)               div_q <= DIV_RELOAD;
    else if (div_q == '0)  div_q <= DIV_RELOAD;
    else                   div_q <= div_q - 1'b1;
  end

  assign tick = (div_q == '0);

`ifdef NMR_ACQ_TIMESTAMP_EN
  logic [31:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst)                                   ts_q <= '0;
    else if (state_q == S_ARMED && sync_rise)  ts_q <= '0;
    else if (tick)                             ts_q <= ts_q + 32'd1;
  end
`endif

  // ---------------------------------------------------------------- control
  assign arm_accept = arm_rise & (state_q == S_IDLE || state_q == S_DONE);
  assign enter_cap  = (state_q == S_WAIT_BLANK && blank_fall && dly_cfg_q == '0) ||
                      (state_q == S_DELAY && tick && dly_q == 32'd1);
  assign cap_beat   = (state_q == S_CAPTURE) && adc_valid;
  assign win_end    = (enter_cap && len_cfg_q == '0) || (cap_beat && smp_q == 16'd1);
  assign last_win   = ({1'b0, win_done_q} + 17'd1) == {1'b0, win_cfg_q};

  // Blanked samples still occupy a slot so the window length never changes
  assign sample_ext = blank_in ? 32'd0
                               : {{(32-DATA_W){adc_data[DATA_W-1]}}, adc_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dly_cfg_q  <= '0;
      len_cfg_q  <= '0;
      win_cfg_q  <= '0;
      dly_q      <= '0;
      smp_q      <= '0;
      win_done_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm_rise) begin
            dly_cfg_q <= acq_dly_in;
            len_cfg_q <= acq_len_in;
            win_cfg_q <= win_cnt_in;
            state_q   <= S_ARMED;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        S_ARMED: begin
          if (sync_rise) begin
            win_done_q <= '0;
            if (win_cfg_q == '0) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT_BLANK;
            end
          end
        end
        S_WAIT_BLANK: begin
          if (blank_fall) begin
            dly_q <= dly_cfg_q;
            if (dly_cfg_q != '0) state_q <= S_DELAY;
          end
        end
        S_DELAY: begin
          if (tick) dly_q <= dly_q - 32'd1;
        end
        S_CAPTURE: begin
          if (cap_beat) smp_q <= smp_q - 16'd1;
        end
        default: state_q <= S_IDLE;
      endcase

      // NOTE: non-blocking assignments later in the block win, so window
      // completion below overrides the CAPTURE entry for zero-length windows.
      if (enter_cap) begin
        smp_q   <= len_cfg_q;
        state_q <= S_CAPTURE;
      end
      if (win_end) begin
        win_done_q <= win_done_q + 16'd1;
        if (last_win) begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end else begin
          state_q <= S_WAIT_BLANK;
        end
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    wr_last = 1'b0;
`ifdef NMR_ACQ_TIMESTAMP_EN
    if (enter_cap) begin
      wr_en   = 1'b1;
      wr_data = ts_q;
      wr_last = (len_cfg_q == '0);
    end
`endif
    if (cap_beat) begin
      wr_en   = 1'b1;
      wr_data = sample_ext;
      wr_last = (smp_q == 16'd1);
    end
  end

  // ---------------------------------------------------------------- FIFO
  logic [32:0]      mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full, rd_fire, wr_fire;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                      (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign rd_fire    = ~fifo_empty & m_axis.tready;
  assign wr_fire    = wr_en & (~fifo_full | rd_fire);

  // NOTE: storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr_q[FIFO_AW-1:0]] <= {wr_last, wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (arm_accept)                          overflow_q <= 1'b0;
      else if (wr_en && fifo_full && !rd_fire) overflow_q <= 1'b1;
    end
  end

  assign m_axis.tvalid = ~fifo_empty;
  assign {m_axis.tlast, m_axis.tdata} = fifo_empty ? 33'd0 : mem[rd_ptr_q[FIFO_AW-1:0]];

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule
